// File: rtl/if_fetch_pkg.sv
// Shared IF-stage definitions: bus widths, stall encoding, reset PC and FSM state codes.
// Mirrors the legacy defines.vh so IF/ID agree on bus layouts.
package if_fetch_pkg;

    localparam int IF_TO_ID_WD = 33;
    localparam int BR_WD       = 33;
    localparam int STALL_WD    = 6;

    typedef logic [STALL_WD-1:0] StallBus;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;

    localparam logic [1:0] IF_BOOT       = 2'd0;
    localparam logic [1:0] IF_RUN        = 2'd1;
    localparam logic [1:0] IF_HOLD       = 2'd2;
    localparam logic [1:0] IF_HOLD_REDIR = 2'd3;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// IF-stage bundle: stall/branch inputs from ID, IF->ID bus and inst-SRAM read port.
interface if_fetch_if;
    import if_fetch_pkg::*;

    StallBus                stall;
    logic [BR_WD-1:0]       br_bus;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic                   fetch_adel;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;
    logic [31:0]            fetch_cnt;

    modport master (
        input  stall, br_bus,
        output if_to_id_bus, fetch_adel, inst_sram_en, inst_sram_wen,
               inst_sram_addr, inst_sram_wdata, fetch_cnt
    );

    modport slave (
        output stall, br_bus,
        input  if_to_id_bus, fetch_adel, inst_sram_en, inst_sram_wen,
               inst_sram_addr, inst_sram_wdata, fetch_cnt
    );

endinterface

// File: rtl/if_fetch_redirect_buf.sv
// Holds a branch redirect that arrived while the PC was stalled; the latest capture wins.
module if_redirect_buf
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] br_addr,
    output logic        pend_v,
    output logic [31:0] pend_addr
);

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v    <= 1'b0;
            pend_addr <= 32'h0;
        end else if (capture) begin
            pend_v    <= 1'b1;
            pend_addr <= br_addr;
        end else if (clear) begin
            pend_v    <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues inst-SRAM reads and drives the IF->ID bus.
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    if_fetch_if.master bus
);

    logic [1:0]  state;
    logic [31:0] pc_reg;
    logic        ce_reg;
    logic        adel_reg;
    logic [31:0] cnt_reg;
    logic        pend_v;
    logic [31:0] pend_addr;

    logic        stop;
    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] next_pc;
    logic        pc_load;
    logic        unused_stall_hi;

    assign stop            = (bus.stall[0] == Stop);
    assign unused_stall_hi = ^bus.stall[STALL_WD-1:1];
    assign br_e            = bus.br_bus[32];
    assign br_addr         = bus.br_bus[31:0];

    // A held redirect outranks a live branch; a branch during release of a held redirect is dropped.
    assign next_pc = pend_v ? pend_addr : (br_e ? br_addr : pc_reg + 32'd4);
    // BOOT loads the PC unconditionally, so the SRAM address must follow that load.
    assign pc_load = (state == IF_BOOT) || !stop;

    if_redirect_buf u_redirect_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (stop && br_e && (state != IF_BOOT)),
        .clear     (!stop && (state == IF_HOLD_REDIR)),
        .br_addr   (br_addr),
        .pend_v    (pend_v),
        .pend_addr (pend_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IF_BOOT;
            pc_reg   <= RESET_PC;
            ce_reg   <= 1'b0;
            adel_reg <= 1'b0;
            cnt_reg  <= 32'h0;
        end else begin
            if (pc_load) begin
                pc_reg   <= next_pc;
                adel_reg <= is_misaligned(next_pc);
            end
            case (state)
                IF_BOOT: begin
                    ce_reg <= 1'b1;
                    state  <= IF_RUN;
                end
                IF_RUN: begin
                    if (!stop)     cnt_reg <= cnt_reg + 32'd1;
                    else if (br_e) state   <= IF_HOLD_REDIR;
                    else           state   <= IF_HOLD;
                end
                IF_HOLD: begin
                    if (!stop)     state <= IF_RUN;
                    else if (br_e) state <= IF_HOLD_REDIR;
                end
                default: begin
                    if (!stop) state <= IF_RUN;
                end
            endcase
        end
    end

    assign bus.inst_sram_addr  = pc_load ? next_pc : pc_reg;
    assign bus.inst_sram_en    = rst_n && !is_misaligned(bus.inst_sram_addr);
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_wdata = 32'h0;
    assign bus.if_to_id_bus    = ce_reg ? {1'b1, pc_reg} : '0;
    assign bus.fetch_adel      = adel_reg;
    assign bus.fetch_cnt       = cnt_reg;

endmodule

// File: tb/tb_if_fetch.sv
// Directed + randomized bench for if_fetch against a cycle-level behavioural model.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    if_fetch_if bus ();

    if_fetch u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: a PC that has booted or not, a pending redirect, and whether the previous cycle was stalled.
    bit          m_booted;
    logic [31:0] m_pc;
    logic        m_adel;
    logic [31:0] m_cnt;
    bit          m_pend_v;
    logic [31:0] m_pend_addr;
    bit          m_prev_stop;

    task automatic model_reset();
        m_booted    = 1'b0;
        m_pc        = RESET_PC;
        m_adel      = 1'b0;
        m_cnt       = 32'h0;
        m_pend_v    = 1'b0;
        m_pend_addr = 32'h0;
        m_prev_stop = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_bus",  64'(bus.if_to_id_bus), 64'h0);
        chk("rst_en",   64'(bus.inst_sram_en), 64'h0);
        chk("rst_adel", 64'(bus.fetch_adel),   64'h0);
        chk("rst_cnt",  64'(bus.fetch_cnt),    64'h0);
    endtask

    task automatic step(input logic stop, input logic br_e, input logic [31:0] br_addr);
        logic [31:0] tgt;
        logic [31:0] exp_addr;
        logic [32:0] exp_bus;
        StallBus     st;
        st         = StallBus'($urandom);
        st[0]      = stop ? Stop : NoStop;
        bus.stall  = st;
        bus.br_bus = {br_e, br_addr};
        tgt        = m_pend_v ? m_pend_addr : (br_e ? br_addr : m_pc + 32'd4);
        exp_addr   = !m_booted ? m_pc + 32'd4 : (stop ? m_pc : tgt);
        exp_bus    = m_booted ? {1'b1, m_pc} : 33'h0;
        @(negedge clk);
        chk("addr", 64'(bus.inst_sram_addr), 64'(exp_addr));
        chk("en",   64'(bus.inst_sram_en),   64'(exp_addr[1:0] == 2'b00));
        chk("bus",  64'(bus.if_to_id_bus),   64'(exp_bus));
        chk("adel", 64'(bus.fetch_adel),     64'(m_adel));
        chk("cnt",  64'(bus.fetch_cnt),      64'(m_cnt));
        @(posedge clk);
        if (!m_booted) begin
            m_pc        = m_pc + 32'd4;
            m_adel      = (m_pc[1:0] != 2'b00);
            m_booted    = 1'b1;
            m_prev_stop = 1'b0;
        end else if (stop) begin
            if (br_e) begin
                m_pend_v    = 1'b1;
                m_pend_addr = br_addr;
            end
            m_prev_stop = 1'b1;
        end else begin
            if (!m_prev_stop) m_cnt = m_cnt + 32'd1;
            m_pc        = tgt;
            m_adel      = (tgt[1:0] != 2'b00);
            m_pend_v    = 1'b0;
            m_prev_stop = 1'b0;
        end
        #1;
    endtask

    initial begin
        logic [31:0] r;
        rst_n      = 1'b0;
        bus.stall  = '0;
        bus.br_bus = '0;
        model_reset();
        #2;
        check_reset_outputs();
        chk("wen",   64'(bus.inst_sram_wen),   64'h0);
        chk("wdata", 64'(bus.inst_sram_wdata), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Boot and straight-line fetch
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
        // Branch in RUN
        step(1'b0, 1'b1, 32'hBFC0_0100);
        step(1'b0, 1'b0, 32'h0);
        // Stall 3 cycles with a branch in the middle one
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h8000_1000);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        // Last held redirect wins; branch on release is dropped
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h8000_2000);
        step(1'b1, 1'b1, 32'h8000_3000);
        step(1'b0, 1'b1, 32'h8000_4000);
        step(1'b0, 1'b0, 32'h0);
        // Misaligned target
        step(1'b0, 1'b1, 32'hBFC0_0102);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hBFC0_0200);
        step(1'b0, 1'b0, 32'h0);
        // PC wrap at the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            if ($urandom_range(0, 7) != 0) r[1:0] = 2'b00;
            step(($urandom_range(0, 9) < 3), ($urandom_range(0, 4) == 0), r);
        end

        // Asynchronous reset while a redirect is held
        step(1'b0, 1'b1, 32'hBFC0_0302);
        step(1'b1, 1'b1, 32'h8000_5000);
        step(1'b1, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        bus.stall  = '0;
        bus.br_bus = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
